// File: rtl/mod_sha256_compress.sv
// SHA-256 compression engine: runs 64 rounds over a streamed message schedule
// against an internal K ROM and folds the result into the supplied chaining value.
module mod_sha256_compress (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         START,
    input  logic [255:0] H_IN,
    input  logic [31:0]  W_IN,
    input  logic         W_VLD,
    output logic [5:0]   I_OUT,
    output logic         BUSY,
    output logic         DONE,
    output logic [255:0] H_OUT
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    logic [1:0]   state_q, state_d;
    logic [5:0]   idx_q, idx_d;
    logic [31:0]  wv_q [8];
    logic [31:0]  wv_d [8];
    logic [31:0]  hreg_q [8];
    logic [31:0]  hreg_d [8];
    logic [255:0] hout_q, hout_d;
    logic         done_q, done_d;

    logic [31:0] k_word, sig0, sig1, ch, maj, t1, t2;

    // Working variables a..h live in wv_q[0..7]; one round is evaluated per accepted word.
    always_comb begin
        k_word = K_ROM[idx_q];
        sig0   = rotr(wv_q[0], 2) ^ rotr(wv_q[0], 13) ^ rotr(wv_q[0], 22);
        sig1   = rotr(wv_q[4], 6) ^ rotr(wv_q[4], 11) ^ rotr(wv_q[4], 25);
        ch     = (wv_q[4] & wv_q[5]) ^ (~wv_q[4] & wv_q[6]);
        maj    = (wv_q[0] & wv_q[1]) ^ (wv_q[0] & wv_q[2]) ^ (wv_q[1] & wv_q[2]);
        t1     = wv_q[7] + sig1 + ch + k_word + W_IN;
        t2     = sig0 + maj;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wv_d    = wv_q;
        hreg_d  = hreg_q;
        hout_d  = hout_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    for (int j = 0; j < 8; j++) begin
                        hreg_d[j] = H_IN[255 - 32*j -: 32];
                        wv_d[j]   = H_IN[255 - 32*j -: 32];
                    end
                    idx_d   = 6'd0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                if (W_VLD) begin
                    wv_d[7] = wv_q[6];
                    wv_d[6] = wv_q[5];
                    wv_d[5] = wv_q[4];
                    wv_d[4] = wv_q[3] + t1;
                    wv_d[3] = wv_q[2];
                    wv_d[2] = wv_q[1];
                    wv_d[1] = wv_q[0];
                    wv_d[0] = t1 + t2;
                    if (idx_q == 6'd63) begin
                        state_d = S_FINAL;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
            S_FINAL: begin
                for (int j = 0; j < 8; j++) begin
                    hout_d[255 - 32*j -: 32] = hreg_q[j] + wv_q[j];
                end
                done_d  = 1'b1;
                idx_d   = 6'd0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 6'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            idx_q   <= 6'd0;
            hout_q  <= 256'd0;
            done_q  <= 1'b0;
            for (int j = 0; j < 8; j++) begin
                wv_q[j]   <= 32'd0;
                hreg_q[j] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            hout_q  <= hout_d;
            done_q  <= done_d;
            for (int j = 0; j < 8; j++) begin
                wv_q[j]   <= wv_d[j];
                hreg_q[j] <= hreg_d[j];
            end
        end
    end

    assign I_OUT = idx_q;
    assign BUSY  = (state_q != S_IDLE);
    assign DONE  = done_q;
    assign H_OUT = hout_q;

endmodule

// File: tb/tb_mod_sha256_compress.sv
// Self-checking bench for mod_sha256_compress: acts as the W-memory producer and
// compares digests against known vectors and a whole-block SHA-256 reference model.
module tb_mod_sha256_compress;

    logic         CLK;
    logic         RST_N;
    logic         START;
    logic [255:0] H_IN;
    logic [31:0]  W_IN;
    logic         W_VLD;
    logic [5:0]   I_OUT;
    logic         BUSY;
    logic         DONE;
    logic [255:0] H_OUT;

    mod_sha256_compress dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .H_IN  (H_IN),
        .W_IN  (W_IN),
        .W_VLD (W_VLD),
        .I_OUT (I_OUT),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .H_OUT (H_OUT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    localparam logic [31:0] K_TB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_H = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_H = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    typedef struct {
        logic [255:0] h_in;
        logic [511:0] blk;
        logic [255:0] exp_h;
        int           stall_pct;
    } vec_t;

    int total_checks;
    int passed_checks;
    logic [31:0] sched_g [64];

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] get_word(input logic [511:0] blk, input int t);
        return blk[511 - 32*t -: 32];
    endfunction

    // Standard SHA-256 schedule expansion, used both as the W-memory producer and by the model.
    task automatic build_sched(input logic [511:0] blk);
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                sched_g[t] = get_word(blk, t);
            end else begin
                sched_g[t] = (rotr(sched_g[t-2], 17) ^ rotr(sched_g[t-2], 19) ^ (sched_g[t-2] >> 10))
                           + sched_g[t-7]
                           + (rotr(sched_g[t-15], 7) ^ rotr(sched_g[t-15], 18) ^ (sched_g[t-15] >> 3))
                           + sched_g[t-16];
            end
        end
    endtask

    // Whole-block compression, straight from the algorithm description.
    function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] res;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = get_word(blk, t);
            else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                      + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        end
        for (int j = 0; j < 8; j++) v[j] = h[255 - 32*j -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K_TB[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int j = 0; j < 8; j++) res[255 - 32*j -: 32] = h[255 - 32*j -: 32] + v[j];
        return res;
    endfunction

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        total_checks++;
        if (act === exp) begin
            passed_checks++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one block; must be called just after a negedge. Returns right after the
    // negedge that follows the DONE edge, so a chained block can start in the DONE cycle.
    task automatic apply_stimulus(input logic [255:0] hin, input logic [511:0] blk,
                                  input int stall_pct, input int inject_at,
                                  output logic [255:0] digest, output int cycles,
                                  output int stalls, output int idx_err);
        int rounds;
        logic vld;
        build_sched(blk);
        rounds  = 0;
        stalls  = 0;
        idx_err = 0;
        cycles  = -1;
        START = 1'b1;
        H_IN  = hin;
        W_VLD = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        H_IN  = ~hin;
        check_output("busy_after_start", {254'd0, BUSY, DONE}, 256'd2);
        for (int k = 1; k <= 400; k++) begin
            if (I_OUT !== ((rounds > 63) ? 6'd63 : 6'(rounds))) idx_err++;
            vld = ($urandom_range(99) >= stall_pct);
            W_VLD = vld;
            W_IN  = vld ? sched_g[I_OUT] : $urandom;
            if (rounds == inject_at) begin
                START = 1'b1;
                H_IN  = {8{$urandom}};
            end else begin
                START = 1'b0;
            end
            if (rounds < 64) begin
                if (vld) rounds++;
                else stalls++;
            end
            @(posedge CLK);
            @(negedge CLK);
            if (DONE === 1'b1) begin
                cycles = k;
                break;
            end
        end
        START  = 1'b0;
        W_VLD  = 1'b0;
        digest = H_OUT;
    endtask

    vec_t vecs [6];
    logic [255:0] digest, d1;
    logic [511:0] abc_blk, empty_blk, blk1, blk2;
    int cycles, stalls, idx_err, done_seen;

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        RST_N = 1'b0;
        START = 1'b0;
        H_IN  = '0;
        W_IN  = '0;
        W_VLD = 1'b0;

        abc_blk   = {32'h61626380, 448'd0, 32'h00000018};
        empty_blk = {32'h80000000, 480'd0};
        blk1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768,
                32'h66676869, 32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d,
                32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h0};
        blk2 = {480'd0, 32'h000001c0};

        vecs[0] = '{IV, abc_blk, ABC_H, 0};
        vecs[1] = '{IV, empty_blk, EMPTY_H, 0};
        vecs[2] = '{IV, abc_blk, ABC_H, 30};
        for (int r = 3; r < 6; r++) begin
            for (int j = 0; j < 16; j++) vecs[r].blk[511 - 32*j -: 32] = $urandom;
            vecs[r].h_in      = (r == 3) ? IV : {8{$urandom}};
            for (int j = 0; j < 8; j++) vecs[r].h_in[255 - 32*j -: 32] ^= $urandom;
            vecs[r].exp_h     = ref_compress(vecs[r].h_in, vecs[r].blk);
            vecs[r].stall_pct = (r == 5) ? 40 : 20;
        end

        repeat (3) @(negedge CLK);
        check_output("reset_state", {248'd0, I_OUT, BUSY, DONE}, 256'd0);
        check_output("reset_hout", H_OUT, 256'd0);
        RST_N = 1'b1;

        for (int r = 0; r < 6; r++) begin
            apply_stimulus(vecs[r].h_in, vecs[r].blk, vecs[r].stall_pct, -1, digest, cycles, stalls, idx_err);
            check_output($sformatf("vec%0d_digest", r), digest, vecs[r].exp_h);
            check_output($sformatf("vec%0d_latency", r), 256'(cycles), 256'(65 + stalls));
            check_output($sformatf("vec%0d_index", r), 256'(idx_err), 256'd0);
        end

        // START with a different H_IN at round 10 must not disturb the block.
        apply_stimulus(IV, abc_blk, 0, 10, digest, cycles, stalls, idx_err);
        check_output("busy_start_digest", digest, ABC_H);
        check_output("busy_start_latency", 256'(cycles), 256'd65);

        // Two-block message, second START issued in the DONE cycle of the first.
        apply_stimulus(IV, blk1, 15, -1, d1, cycles, stalls, idx_err);
        check_output("chain_block1", d1, ref_compress(IV, blk1));
        apply_stimulus(d1, blk2, 15, -1, digest, cycles, stalls, idx_err);
        check_output("chain_digest", digest, TWO_H);
        check_output("chain_latency", 256'(cycles), 256'(65 + stalls));

        // Abort a block at round 30 with an asynchronous reset.
        build_sched(abc_blk);
        START = 1'b1;
        H_IN  = IV;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        W_VLD = 1'b1;
        for (int k = 0; k < 30; k++) begin
            W_IN = sched_g[I_OUT];
            @(posedge CLK);
            @(negedge CLK);
        end
        check_output("abort_index", 256'(I_OUT), 256'd30);
        RST_N = 1'b0;
        #1;
        check_output("abort_ctrl", {248'd0, I_OUT, BUSY, DONE}, 256'd0);
        check_output("abort_hout", H_OUT, 256'd0);
        done_seen = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge CLK);
            if (k == 2) RST_N = 1'b1;
            W_IN = sched_g[I_OUT];
            if (DONE === 1'b1) done_seen++;
        end
        W_VLD = 1'b0;
        check_output("abort_no_done", 256'(done_seen), 256'd0);
        check_output("abort_idle", {248'd0, I_OUT, BUSY, DONE}, 256'd0);
        apply_stimulus(IV, abc_blk, 0, -1, digest, cycles, stalls, idx_err);
        check_output("post_reset_digest", digest, ABC_H);
        check_output("post_reset_latency", 256'(cycles), 256'd65);

        @(negedge CLK);
        check_output("done_one_cycle", {255'd0, DONE}, 256'd0);

        $display("[TB] %0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
